// File: rtl/psram_mem_arbiter.sv
// Shares one 16-bit PSRAM controller between the fetch and data ports; each 32-bit access
// becomes two halfword transactions (low first). Define PSRAM_ARB_RR_EN for round-robin grant.
module psram_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        stall,
    output logic        err,
    output logic [21:0] ps_addr,
    output logic        ps_read_en,
    output logic        ps_write_en,
    output logic [15:0] ps_data_in,
    output logic        ps_write_high_byte,
    output logic        ps_write_low_byte,
    input  logic        ps_read_avail,
    input  logic [15:0] ps_data_out,
    input  logic        ps_busy
);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, ACK} state_t;

    state_t        r_state, w_next;
    logic          r_own_d, r_we, r_err, r_rd_en, r_wr_en, r_hb, r_lb;
    logic [20:0]   r_addr;
    logic [3:0]    r_be;
    logic [31:0]   r_wdata, r_rdata;
    logic [21:0]   r_ps_addr;
    logic [15:0]   r_ps_data;
    logic [CW-1:0] r_cnt;
    logic          w_gnt_d, w_lo_en, w_hi_en, w_strb, w_any;
    logic          w_issue, w_hi, w_done, w_tmo;
    logic          w_unused;

    assign w_unused = &{1'b0, i_addr[31:23], i_addr[1:0], d_addr[31:23], d_addr[1:0]};

`ifdef PSRAM_ARB_RR_EN
    logic r_last_d;
    // On contention, the port that was not served last wins.
    assign w_gnt_d = d_req & (~i_req | ~r_last_d);
`else
    assign w_gnt_d = d_req;
`endif

    assign w_any   = i_req | d_req;
    // Reads always transfer both halves; writes skip a half with no enables.
    assign w_lo_en = ~r_we | (|r_be[1:0]);
    assign w_hi_en = ~r_we | (|r_be[3:2]);
    assign w_strb  = r_rd_en | r_wr_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_any) w_next = ISSUE_LO;
            ISSUE_LO: begin
                if (!w_lo_en)      w_next = w_hi_en ? ISSUE_HI : ACK;
                else if (!ps_busy) w_next = WAIT_LO;
            end
            WAIT_LO: begin
                if (w_done)     w_next = w_hi_en ? ISSUE_HI : ACK;
                else if (w_tmo) w_next = ACK;
            end
            ISSUE_HI: if (!ps_busy) w_next = WAIT_HI;
            WAIT_HI:  if (w_done || w_tmo) w_next = ACK;
            ACK:      w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        w_issue = 1'b0;
        w_hi    = 1'b0;
        w_done  = 1'b0;
        w_tmo   = 1'b0;
        i_ack   = 1'b0;
        d_ack   = 1'b0;
        case (r_state)
            ISSUE_LO: w_issue = w_lo_en & ~ps_busy;
            ISSUE_HI: begin
                w_issue = ~ps_busy;
                w_hi    = 1'b1;
            end
            WAIT_LO, WAIT_HI: begin
                w_hi   = (r_state == WAIT_HI);
                // The strobe cycle itself never completes a half.
                w_done = ~w_strb & (r_we ? ~ps_busy : ps_read_avail);
                w_tmo  = ~w_done & (r_cnt == CW'(TIMEOUT_CYCLES - 1));
            end
            ACK: begin
                i_ack = ~r_own_d;
                d_ack = r_own_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_own_d   <= 1'b1;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_rd_en   <= 1'b0;
            r_wr_en   <= 1'b0;
            r_ps_addr <= '0;
            r_ps_data <= '0;
            r_hb      <= 1'b0;
            r_lb      <= 1'b0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_own_d <= w_gnt_d;
                r_addr  <= w_gnt_d ? d_addr[22:2] : i_addr[22:2];
                r_we    <= w_gnt_d & d_we;
                r_be    <= w_gnt_d ? d_be : 4'b0;
                r_wdata <= w_gnt_d ? d_wdata : 32'b0;
            end
            r_rd_en <= w_issue & ~r_we;
            r_wr_en <= w_issue & r_we;
            if (w_issue) begin
                r_ps_addr <= {r_addr, w_hi};
                r_ps_data <= r_we ? (w_hi ? r_wdata[31:16] : r_wdata[15:0]) : 16'h0;
                r_hb      <= r_we & (w_hi ? r_be[3] : r_be[1]);
                r_lb      <= r_we & (w_hi ? r_be[2] : r_be[0]);
            end
            if (w_issue)
                r_cnt <= '0;
            else if (r_state == WAIT_LO || r_state == WAIT_HI)
                r_cnt <= r_cnt + CW'(1);
            if (w_done && !r_we) begin
                if (w_hi) r_rdata[31:16] <= ps_data_out;
                else      r_rdata[15:0]  <= ps_data_out;
            end
            if (w_tmo) r_err <= 1'b1;
        end
    end

`ifdef PSRAM_ARB_RR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                    r_last_d <= 1'b0;
        else if (r_state == IDLE && w_any) r_last_d <= w_gnt_d;
    end
`endif

    assign i_rdata            = r_rdata;
    assign d_rdata            = r_rdata;
    assign err                = r_err;
    assign ps_addr            = r_ps_addr;
    assign ps_read_en         = r_rd_en;
    assign ps_write_en        = r_wr_en;
    assign ps_data_in         = r_ps_data;
    assign ps_write_high_byte = r_hb;
    assign ps_write_low_byte  = r_lb;
    assign stall              = (i_req & ~i_ack) | (d_req & ~d_ack);

endmodule
